// File: rtl/VX_gpu_pkg.sv
// Shared GPU core types used by the CSR drain gate.
// Holds the drain-gate FSM state encoding.
package VX_gpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        ISSUE = 2'd2
    } csr_drain_state_e;

endpackage

// File: rtl/vx_csr_drain_gate.sv
// Holds one CSR request until its warp has no instructions in flight, then offers it to the CSR unit.
// Latency: 1 cycle accept->out_valid on bypass, >=2 cycles through DRAIN; no same-cycle pass-through.
// Backpressure: in_ready only in IDLE; payload held stable while out_valid && !out_ready. Optional CSR_DRAIN_PERF_EN.
module vx_csr_drain_gate
    import VX_gpu_pkg::*;
#(
    parameter int DATAW       = 128,
    parameter int NW_WIDTH    = 2,
    parameter int DRAIN_LIMIT = 1024
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATAW-1:0]    in_data,
    input  logic [NW_WIDTH-1:0] in_wid,
    input  logic                in_bypass,
    output logic [NW_WIDTH-1:0] alm_empty_wid,
    input  logic                alm_empty,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATAW-1:0]    out_data,
    output logic                drain_timeout
`ifdef CSR_DRAIN_PERF_EN
    ,
    output logic [31:0]         drain_stall_cycles
`endif
);

    localparam int CNTW = $clog2(DRAIN_LIMIT + 1);
    localparam logic [CNTW-1:0] LIMIT_C = CNTW'(DRAIN_LIMIT);

    csr_drain_state_e      state_q;
    csr_drain_state_e      state_d;
    logic [DATAW-1:0]      data_q;
    logic [NW_WIDTH-1:0]   wid_q;
    logic                  bypass_q;
    logic [CNTW-1:0]       drain_cnt_q;
    logic                  timeout_q;
    logic                  accept;
    logic                  drain_active;

    assign in_ready      = (state_q == IDLE);
    assign accept        = in_valid && in_ready;
    assign out_valid     = (state_q == ISSUE);
    assign out_data      = data_q;
    assign alm_empty_wid = (state_q == IDLE) ? in_wid : wid_q;
    assign drain_timeout = timeout_q;
    assign drain_active  = (state_q == DRAIN) && !bypass_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = in_bypass ? ISSUE : DRAIN;
            DRAIN:   if (alm_empty) state_d = ISSUE;
            ISSUE:   if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload bank loads only on acceptance, so it is frozen until the FSM is back in IDLE.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_q   <= in_data;
            wid_q    <= in_wid;
            bypass_q <= in_bypass;
        end
    end

    // Watchdog only reports a stuck drain; it never forces the request out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drain_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            if (accept && !in_bypass) begin
                drain_cnt_q <= '0;
            end else if (drain_active && (drain_cnt_q != LIMIT_C)) begin
                drain_cnt_q <= drain_cnt_q + 1'b1;
            end
            if (drain_active && (drain_cnt_q >= LIMIT_C - 1'b1)) begin
                timeout_q <= 1'b1;
            end
        end
    end

`ifdef CSR_DRAIN_PERF_EN
    logic [31:0] drain_stall_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drain_stall_q <= '0;
        end else if (state_q == DRAIN) begin
            drain_stall_q <= drain_stall_q + 32'd1;
        end
    end

    assign drain_stall_cycles = drain_stall_q;
`endif

endmodule

// File: tb/tb_vx_csr_drain_gate.sv
// Directed bench for vx_csr_drain_gate: vector table of single requests plus watchdog and reset sequences.
module tb_vx_csr_drain_gate;

    localparam int DATAW = 128;
    localparam int NWW   = 2;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [DATAW-1:0] in_data;
    logic [NWW-1:0]   in_wid;
    logic             in_bypass;
    logic [NWW-1:0]   alm_empty_wid;
    logic             alm_empty;
    logic             out_valid;
    logic             out_ready;
    logic [DATAW-1:0] out_data;
    logic             drain_timeout;
`ifdef CSR_DRAIN_PERF_EN
    logic [31:0]      drain_stall_cycles;
`endif

    vx_csr_drain_gate #(
        .DATAW(DATAW),
        .NW_WIDTH(NWW),
        .DRAIN_LIMIT(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_wid(in_wid),
        .in_bypass(in_bypass),
        .alm_empty_wid(alm_empty_wid),
        .alm_empty(alm_empty),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .drain_timeout(drain_timeout)
`ifdef CSR_DRAIN_PERF_EN
        ,
        .drain_stall_cycles(drain_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NWW-1:0]   wid;
        logic             bypass;
        logic [DATAW-1:0] data;
        int               busy;     // DRAIN cycles with alm_empty=0 before it rises
        int               stall;    // ISSUE cycles with out_ready=0
        int               exp_lat;  // acceptance edge -> first out_valid cycle
        logic             exp_to;
    } vec_t;

    vec_t vecs[6];
    int   n_chk = 0;
    int   n_err = 0;
    int   xfers = 0;
    int   exp_xfers = 0;

    always @(posedge clk) if (out_valid && out_ready) xfers++;

    task automatic chk(input string name, input logic [DATAW-1:0] got, input logic [DATAW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        lat = -1;
        in_wid    = v.wid;
        in_data   = v.data;
        in_bypass = v.bypass;
        in_valid  = 1'b1;
        alm_empty = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("idle_in_ready", in_ready, 1);
        chk("idle_alm_wid", alm_empty_wid, v.wid);
        tick;
        in_valid  = 1'b0;
        in_data   = ~v.data;
        in_wid    = ~v.wid;
        in_bypass = ~v.bypass;
        for (int c = 1; c <= 40; c++) begin
            alm_empty = (c > v.busy);
            out_ready = c[0];
            #1;
            chk("busy_alm_wid", alm_empty_wid, v.wid);
            chk("busy_in_ready", in_ready, 0);
            if (out_valid) begin
                lat = c;
                break;
            end
            tick;
        end
        chk("latency", lat, v.exp_lat);
        if (lat < 0) return;
        for (int s = 0; s < v.stall; s++) begin
            out_ready = 1'b0;
            alm_empty = s[0];
            #1;
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_data", out_data, v.data);
            chk("stall_in_ready", in_ready, 0);
            tick;
        end
        out_ready = 1'b1;
        #1;
        chk("xfer_out_valid", out_valid, 1);
        chk("xfer_out_data", out_data, v.data);
        tick;
        exp_xfers++;
        out_ready = 1'b0;
        chk("post_out_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
        chk("xfer_count", xfers, exp_xfers);
        chk("timeout_flag", drain_timeout, v.exp_to);
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{2'd1, 1'b1, 128'h0123_4567_89ab_cdef_0011_2233_4455_6677, 0, 0, 1, 1'b0};
        vecs[1] = '{2'd2, 1'b0, 128'hdead_beef_cafe_f00d_1357_9bdf_2468_ace0, 4, 0, 6, 1'b0};
        vecs[2] = '{2'd3, 1'b0, 128'hffff_0000_ffff_0000_a5a5_5a5a_0f0f_f0f0, 0, 0, 2, 1'b0};
        vecs[3] = '{2'd0, 1'b0, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1, 3, 3, 1'b0};
        vecs[4] = '{2'd2, 1'b1, 128'h8000_0000_0000_0000_0000_0000_0000_0001, 0, 2, 1, 1'b0};
        vecs[5] = '{2'd1, 1'b0, 128'h0f1e_2d3c_4b5a_6978_8796_a5b4_c3d2_e1f0, 6, 1, 8, 1'b0};

        reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_wid = '0;
        in_bypass = 1'b0; alm_empty = 1'b0; out_ready = 1'b1;
        tick; tick;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_timeout", drain_timeout, 0);
        reset_n = 1'b1;
        tick;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_no_xfer", xfers, 0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Watchdog: stuck drain sets the flag after the 8th DRAIN cycle but keeps waiting.
        in_wid = 2'd3; in_data = 128'h5a5a; in_bypass = 1'b0; in_valid = 1'b1; alm_empty = 1'b0;
        tick;
        in_valid = 1'b0;
        for (int c = 1; c < 8; c++) tick;
        chk("wd_before_limit", drain_timeout, 0);
        tick;
        chk("wd_at_limit", drain_timeout, 1);
        for (int c = 0; c < 4; c++) tick;
        chk("wd_still_waiting", out_valid, 0);
        chk("wd_alm_wid", alm_empty_wid, 3);
        alm_empty = 1'b1;
        tick;
        chk("wd_issue", out_valid, 1);
        out_ready = 1'b1;
        tick;
        exp_xfers++;
        out_ready = 1'b0;
        chk("wd_done_in_ready", in_ready, 1);
        chk("wd_sticky", drain_timeout, 1);
        v = '{2'd0, 1'b1, 128'h77, 0, 0, 1, 1'b1};
        run_vec(v);

        // Reset while draining discards the request.
        in_wid = 2'd1; in_data = 128'h99; in_bypass = 1'b0; in_valid = 1'b1; alm_empty = 1'b0;
        tick;
        in_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst_drain_in_ready", in_ready, 1);
        chk("rst_drain_timeout", drain_timeout, 0);
        tick;
        reset_n = 1'b1;
        alm_empty = 1'b1; out_ready = 1'b1;
        tick; tick;
        chk("rst_drain_no_issue", out_valid, 0);
        chk("rst_drain_no_xfer", xfers, exp_xfers);
        out_ready = 1'b0;

        // Reset while issuing drops out_valid asynchronously with no transfer.
        in_wid = 2'd2; in_data = 128'hab; in_bypass = 1'b1; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        chk("rst_iss_valid", out_valid, 1);
        out_ready = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("rst_iss_drop", out_valid, 0);
        tick;
        reset_n = 1'b1;
        tick;
        chk("rst_iss_in_ready", in_ready, 1);
        chk("rst_iss_no_xfer", xfers, exp_xfers);
        out_ready = 1'b0;

`ifdef CSR_DRAIN_PERF_EN
        v = '{2'd1, 1'b0, 128'h31, 2, 0, 4, 1'b0};
        run_vec(v);
        v = '{2'd2, 1'b0, 128'h32, 4, 0, 6, 1'b0};
        run_vec(v);
        chk("perf_sum", drain_stall_cycles, 8);
        dut.drain_stall_q = 32'hFFFF_FFFD;
        v = '{2'd3, 1'b0, 128'h33, 2, 0, 4, 1'b0};
        run_vec(v);
        chk("perf_wrap", drain_stall_cycles, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "timeout");
    end

endmodule
